// File: rtl/screen_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | screen_arbiter_if : requester/screen_writer bundle for screen_arbiter      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface screen_arbiter_if #(
  parameter int N            = 4,
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3
);
  logic [N-1:0]              req;
  logic [N*COLOUR_WIDTH-1:0] req_colour;
  logic [N*WIDTH-1:0]        req_x_min;
  logic [N*WIDTH-1:0]        req_y_min;
  logic [N*WIDTH-1:0]        req_x_range;
  logic [N*WIDTH-1:0]        req_y_range;
  logic [N-1:0]              ack;
  logic [N-1:0]              grant;
  logic                      busy;
  logic                      screen_start;
  logic [COLOUR_WIDTH-1:0]   new_screen_colour;
  logic [WIDTH-1:0]          screen_x_min;
  logic [WIDTH-1:0]          screen_y_min;
  logic [WIDTH-1:0]          screen_x_range;
  logic [WIDTH-1:0]          screen_y_range;
  logic                      screen_done;

  // Master is the requester / screen_writer side, slave is the arbiter.
  modport master (
    output req, req_colour, req_x_min, req_y_min, req_x_range, req_y_range,
           screen_done,
    input  ack, grant, busy, screen_start, new_screen_colour,
           screen_x_min, screen_y_min, screen_x_range, screen_y_range
  );

  modport slave (
    input  req, req_colour, req_x_min, req_y_min, req_x_range, req_y_range,
           screen_done,
    output ack, grant, busy, screen_start, new_screen_colour,
           screen_x_min, screen_y_min, screen_x_range, screen_y_range
  );
endinterface
`default_nettype wire

// File: rtl/screen_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | screen_arbiter : round-robin sharing of one screen_writer between N users  |
// | Option macro SCREEN_ARB_FIXED_PRIORITY_EN selects lowest-index-wins.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module screen_arbiter #(
  parameter int N            = 4,
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3
) (
  input  logic            clock,
  input  logic            resetn,
  screen_arbiter_if.slave bus
);
  localparam int           c_IDX_W = $clog2(N);
  localparam logic [N-1:0] c_ONE   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [N-1:0]            r_grant;
  logic [N-1:0]            r_ack;
  logic                    r_busy;
  logic                    r_start;
  logic [COLOUR_WIDTH-1:0] r_colour;
  logic [WIDTH-1:0]        r_x_min;
  logic [WIDTH-1:0]        r_y_min;
  logic [WIDTH-1:0]        r_x_range;
  logic [WIDTH-1:0]        r_y_range;

  logic [COLOUR_WIDTH-1:0] w_colour  [N];
  logic [WIDTH-1:0]        w_x_min   [N];
  logic [WIDTH-1:0]        w_y_min   [N];
  logic [WIDTH-1:0]        w_x_range [N];
  logic [WIDTH-1:0]        w_y_range [N];
  logic                    w_found;
  logic [c_IDX_W-1:0]      w_win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_colour[gi]  = bus.req_colour[gi*COLOUR_WIDTH +: COLOUR_WIDTH];
      assign w_x_min[gi]   = bus.req_x_min[gi*WIDTH +: WIDTH];
      assign w_y_min[gi]   = bus.req_y_min[gi*WIDTH +: WIDTH];
      assign w_x_range[gi] = bus.req_x_range[gi*WIDTH +: WIDTH];
      assign w_y_range[gi] = bus.req_y_range[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef SCREEN_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found   = 1'b1;
        w_win_idx = c_IDX_W'(i);
      end
    end
  end
`else
  logic [c_IDX_W-1:0] r_last;
  int                 w_cand;

  // Scan from farthest to nearest so the requester just after r_last wins.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_cand    = 0;
    for (int k = N; k >= 1; k--) begin
      w_cand = int'(r_last) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (bus.req[c_IDX_W'(w_cand)]) begin
        w_found   = 1'b1;
        w_win_idx = c_IDX_W'(w_cand);
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_colour  <= '0;
      r_x_min   <= '0;
      r_y_min   <= '0;
      r_x_range <= '0;
      r_y_range <= '0;
`ifndef SCREEN_ARB_FIXED_PRIORITY_EN
      r_last    <= c_IDX_W'(N - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= c_ONE << w_win_idx;
            r_busy    <= 1'b1;
            r_colour  <= w_colour[w_win_idx];
            r_x_min   <= w_x_min[w_win_idx];
            r_y_min   <= w_y_min[w_win_idx];
            r_x_range <= w_x_range[w_win_idx];
            r_y_range <= w_y_range[w_win_idx];
`ifndef SCREEN_ARB_FIXED_PRIORITY_EN
            r_last    <= w_win_idx;
`endif
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_start <= 1'b1;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_start <= 1'b0;
          if (bus.screen_done) begin
            r_ack   <= r_grant;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack   <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant             = r_grant;
  assign bus.ack               = r_ack;
  assign bus.busy              = r_busy;
  assign bus.screen_start      = r_start;
  assign bus.new_screen_colour = r_colour;
  assign bus.screen_x_min      = r_x_min;
  assign bus.screen_y_min      = r_y_min;
  assign bus.screen_x_range    = r_x_range;
  assign bus.screen_y_range    = r_y_range;
endmodule
`default_nettype wire
